// File: rtl/pwm_duty_decoder_if.sv
// PWM decoder signal bundle.
//   enable      decoder enable (low holds the decoder idle)
//   pwm_in      raw, asynchronous PWM line
//   period      last measured rise-to-rise period, sysclk cycles
//   high_time   last measured high time, sysclk cycles
//   duty_valid  one-cycle strobe, period/high_time updated this cycle
//   stuck_low   line has had no rise for TIMEOUT cycles while low
//   stuck_high  line has had no rise for TIMEOUT cycles while high
// master: the side that drives enable/pwm_in; slave: the decoder.
interface pwm_duty_decoder_if #(
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic             pwm_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             duty_valid;
  logic             stuck_low;
  logic             stuck_high;

  modport master (
    output enable, pwm_in,
    input  period, high_time, duty_valid, stuck_low, stuck_high
  );

  modport slave (
    input  enable, pwm_in,
    output period, high_time, duty_valid, stuck_low, stuck_high
  );
endinterface

// File: rtl/pwm_duty_decoder.sv
// PWM duty decoder: samples a PWM line and measures, per frame, the rise-to-rise period and
// the high time in sysclk cycles. Strobes duty_valid once per completed frame and flags a line
// that has not risen for TIMEOUT cycles as stuck low or stuck high.
// Ports:
//   sysclk  system clock, rising edge
//   rst     synchronous active-high reset, priority over everything
//   bus     pwm_duty_decoder_if.slave (enable, pwm_in in; measurements and flags out)
module pwm_duty_decoder #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input logic                sysclk,
  input logic                rst,
  pwm_duty_decoder_if.slave  bus
);

  if (TIMEOUT < 2 || TIMEOUT > (1 << CNT_W) - 1) begin : gen_bad_cfg
    $error("pwm_duty_decoder: TIMEOUT must be in [2, 2^CNT_W-1]");
  end

  localparam logic [CNT_W-1:0] TimeoutVal = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, pwm_s_q, pwm_d_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stuck_low_q, stuck_low_d;
  logic             stuck_high_q, stuck_high_d;
  logic             rise;

  assign rise = pwm_s_q & ~pwm_d_q;

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b0;
      pwm_s_q      <= 1'b0;
      pwm_d_q      <= 1'b0;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      stuck_low_q  <= 1'b0;
      stuck_high_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= bus.pwm_in;
      pwm_s_q      <= sync1_q;
      pwm_d_q      <= pwm_s_q;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      stuck_low_q  <= stuck_low_d;
      stuck_high_q <= stuck_high_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    stuck_low_d  = stuck_low_q;
    stuck_high_d = stuck_high_q;

    if (!bus.enable) begin
      // Disable from any state drops the partial frame; measurements hold.
      state_d      = StIdle;
      cnt_d        = '0;
      hcnt_d       = '0;
      stuck_low_d  = 1'b0;
      stuck_high_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d        = '0;
          hcnt_d       = '0;
          stuck_low_d  = 1'b0;
          stuck_high_d = 1'b0;
          state_d      = StArm;
        end
        StArm: begin
          if (rise) begin
            cnt_d        = One;
            hcnt_d       = One;
            stuck_low_d  = 1'b0;
            stuck_high_d = 1'b0;
            state_d      = StMeasure;
          end else if (cnt_q != TimeoutVal) begin
            cnt_d = cnt_q + One;
          end
        end
        StMeasure: begin
          if (rise) begin
            // Counts exclude the rise cycle itself, which starts the next frame at 1.
            period_d = cnt_q;
            high_d   = hcnt_q;
            valid_d  = 1'b1;
            cnt_d    = One;
            hcnt_d   = One;
          end else if (cnt_q == TimeoutVal) begin
            // cnt stays at TIMEOUT so ARM sees it already saturated.
            stuck_high_d = pwm_s_q;
            stuck_low_d  = ~pwm_s_q;
            state_d      = StArm;
          end else begin
            cnt_d  = cnt_q + One;
            hcnt_d = hcnt_q + CNT_W'(pwm_s_q);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.period     = period_q;
  assign bus.high_time  = high_q;
  assign bus.duty_valid = valid_q;
  assign bus.stuck_low  = stuck_low_q;
  assign bus.stuck_high = stuck_high_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Bench for pwm_duty_decoder: frame-level PWM stimulus (directed plus $urandom frames), a
// reference model that derives expected strobes from the driven waveform, and a monitor that
// pops and compares each strobe. Stuck-flag timing and reset/hold behaviour are checked inline.
module tb_pwm_duty_decoder;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned TIMEOUT = 200;
  localparam int          Tmo     = int'(TIMEOUT);

  logic sysclk = 1'b0;
  logic rst;
  always #5 sysclk = ~sysclk;

  pwm_duty_decoder_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .sysclk (sysclk),
    .rst    (rst),
    .bus    (bus)
  );

  typedef struct {
    int period;
    int high;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Model state: last rise edge index, high samples since it, armed flag, previous sample.
  int   m_last = 0;
  int   m_hi   = 0;
  bit   m_meas = 0;
  bit   m_prev = 0;

  // Stuck-flag transition cycles recorded by the monitor.
  int   sl_rise = -1;
  int   sl_fall = -1;
  int   sh_rise = -1;
  bit   sl_prev = 0;
  bit   sh_prev = 0;

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drive one cycle of inputs and let the model see the sample the coming edge will take.
  task automatic step(input bit p, input bit en, input bit r);
    int   c;
    exp_t e;
    @(negedge sysclk);
    bus.pwm_in = p;
    bus.enable = en;
    rst        = r;
    c          = cyc + 1;
    if (r) begin
      m_meas = 0;
      m_prev = 0;
    end else begin
      if (en && p && !m_prev) begin
        if (m_meas && (c - m_last) <= Tmo) begin
          e.period = c - m_last;
          e.high   = m_hi;
          e.cyc    = c + 2;
          exp_q.push_back(e);
        end
        m_meas = 1;
        m_last = c;
        m_hi   = 1;
      end else begin
        if (!en) m_meas = 0;
        m_hi += int'(p);
      end
      m_prev = p;
    end
  endtask

  task automatic frame(input int period, input int high, input int drop_at = -1,
                       input int drop_len = 0);
    bit en;
    for (int i = 0; i < period; i++) begin
      en = !(drop_at >= 0 && i >= drop_at && i < drop_at + drop_len);
      step(i < high, en, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_period"},     int'(bus.period),     0);
    check({tag, "_high_time"},  int'(bus.high_time),  0);
    check({tag, "_duty_valid"}, int'(bus.duty_valid), 0);
    check({tag, "_stuck_low"},  int'(bus.stuck_low),  0);
    check({tag, "_stuck_high"}, int'(bus.stuck_high), 0);
  endtask

  // Monitor: every strobe must match the head of the queue at the predicted cycle.
  always @(negedge sysclk) begin
    exp_t e;
    if (bus.duty_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe: got period=%0d high_time=%0d, expected none (cycle %0d)",
                 bus.period, bus.high_time, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("period", int'(bus.period), e.period);
        check("high_time", int'(bus.high_time), e.high);
        check("stuck_at_strobe", int'({bus.stuck_low, bus.stuck_high}), 0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_strobe: got none, expected period=%0d high_time=%0d at cycle %0d",
               exp_q[0].period, exp_q[0].high, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (bus.stuck_low === 1'b1 && !sl_prev) sl_rise = cyc;
    if (bus.stuck_low !== 1'b1 && sl_prev)  sl_fall = cyc;
    if (bus.stuck_high === 1'b1 && !sh_prev) sh_rise = cyc;
    sl_prev = (bus.stuck_low === 1'b1);
    sh_prev = (bus.stuck_high === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int p_hold;
    int h_hold;
    int p;
    int h;
    int sweep[3];
    bus.enable = 1'b0;
    bus.pwm_in = 1'b0;
    rst        = 1'b1;

    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 1, 0);
    check_reset_outputs("reset");

    // Nominal 64-cycle frames, then a duty sweep including the extremes.
    repeat (4) frame(64, 33);
    sweep[0] = 1;
    sweep[1] = 62;
    sweep[2] = 63;
    foreach (sweep[k]) repeat (2) frame(64, sweep[k]);

    // Period exactly TIMEOUT is reported; TIMEOUT+1 times out and re-arms.
    frame(64, 10);
    frame(200, 50);
    frame(201, 50);
    frame(64, 20);
    frame(64, 20);

    // Line stuck low.
    frame(64, 33);
    frame(64, 33);
    t0      = m_last;
    sl_rise = -1;
    sl_fall = -1;
    repeat (300) step(0, 1, 0);
    check("stuck_low_onset", sl_rise, t0 + Tmo + 2);
    check("stuck_high_while_low", int'(bus.stuck_high), 0);
    check("period_hold_stuck", int'(bus.period), 64);
    check("high_time_hold_stuck", int'(bus.high_time), 33);
    repeat (3) frame(64, 20);
    check("stuck_low_clear", sl_fall, m_last - 128 + 2);

    // Line stuck high, then reset while stuck_high is set.
    sh_rise = -1;
    step(1, 1, 0);
    t0 = m_last;
    repeat (299) step(1, 1, 0);
    check("stuck_high_onset", sh_rise, t0 + Tmo + 2);
    check("stuck_low_while_high", int'(bus.stuck_low), 0);
    step(1, 1, 1);
    step(1, 1, 0);
    check_reset_outputs("reset_stuck");
    repeat (20) step(1, 1, 0);
    repeat (43) step(0, 1, 0);
    repeat (4) frame(64, 33);

    // Enable dropped mid-frame: the broken frame and the re-arm frame are not reported.
    frame(64, 40);
    frame(64, 33, 45, 10);
    frame(64, 12);
    check("period_hold_disable", int'(bus.period), 64);
    check("high_time_hold_disable", int'(bus.high_time), 40);
    repeat (2) frame(64, 33);

    // Reset mid-frame.
    frame(64, 25);
    frame(64, 25);
    for (int i = 0; i < 64; i++) begin
      step(i < 33, 1, i == 40);
      if (i == 41) check_reset_outputs("reset_mid");
    end
    repeat (4) frame(64, 33);

    // Random frames, some longer than TIMEOUT.
    repeat (40) begin
      p = int'($urandom_range(2, 230));
      h = int'($urandom_range(1, p - 1));
      frame(p, h);
    end
    repeat (5) step(0, 1, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
